// File: rtl/seg7_reader.sv
// seg7_reader: snoops a scanned, multiplexed 7-segment bus and rebuilds the
// displayed hex word. Each digit is captured once its (select, segment) pair
// has been stable long enough; a frame is emitted when every digit was seen.
module seg7_reader #(
    parameter int NDIG   = 8,
    parameter int STABLE = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [7:0]          seg_in,
    input  logic [NDIG-1:0]     dig_sel,
    output logic [4*NDIG-1:0]   value,
    output logic [NDIG-1:0]     dp,
    output logic [NDIG-1:0]     digit_err,
    output logic                err,
    output logic                valid
);

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_SETTLE = 2'd1,
        S_HELD   = 2'd2
    } state_t;

    localparam logic [3:0] CAP_CNT = 4'(STABLE - 1);

    // Registered input pair. The FSM state and counter describe the pair
    // currently held here; next-state logic examines the pair being loaded
    // on the coming edge (dig_sel/seg_in), so a digit is captured on the very
    // edge that registers its STABLE-th identical sample.
    logic [7:0]        r_seg_q;
    logic [NDIG-1:0]   r_sel_q;
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              capture;

    logic [NDIG-1:0]   seen_q, seen_d;
    logic [4*NDIG-1:0] sh_nib_q, sh_nib_d;
    logic [NDIG-1:0]   sh_dp_q, sh_dp_d;
    logic [NDIG-1:0]   sh_err_q, sh_err_d;

    logic [4*NDIG-1:0] value_q, value_d;
    logic [NDIG-1:0]   dp_q, dp_d;
    logic [NDIG-1:0]   derr_q, derr_d;
    logic              err_q, err_d;
    logic              valid_q, valid_d;

    logic              sel_onehot;
    logic              pair_same;
    logic [4:0]        dec;   // {unrecognised, nibble}

    // Inverse of the board's hex-to-segment decoder on segments a..g.
    function automatic logic [4:0] seg_decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h7E:   r = 5'h00;
            7'h30:   r = 5'h01;
            7'h6D:   r = 5'h02;
            7'h79:   r = 5'h03;
            7'h33:   r = 5'h04;
            7'h5B:   r = 5'h05;
            7'h5F:   r = 5'h06;
            7'h70:   r = 5'h07;
            7'h7F:   r = 5'h08;
            7'h7B:   r = 5'h09;
            7'h77:   r = 5'h0A;
            7'h1F:   r = 5'h0B;
            7'h0D:   r = 5'h0C;
            7'h3D:   r = 5'h0D;
            7'h4F:   r = 5'h0E;
            7'h47:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    assign sel_onehot = $onehot(dig_sel);
    assign pair_same  = (dig_sel == r_sel_q) && (seg_in == r_seg_q);

    // Input register, FSM state and stability counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_seg_q <= '0;
            r_sel_q <= '0;
            state_q <= S_WAIT;
            cnt_q   <= '0;
        end else begin
            r_seg_q <= seg_in;
            r_sel_q <= dig_sel;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: count identical samples, capture once STABLE are seen.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (!sel_onehot) begin
            state_d = S_WAIT;
            cnt_d   = '0;
        end else if (!pair_same) begin
            // A one-hot select can never equal a WAIT-state select, so this
            // branch also covers leaving WAIT.
            cnt_d   = '0;
            state_d = S_SETTLE;
            if (cnt_d == CAP_CNT) begin
                state_d = S_HELD;
                capture = 1'b1;
            end
        end else if (state_q == S_SETTLE) begin
            cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
            if (cnt_d == CAP_CNT) begin
                state_d = S_HELD;
                capture = 1'b1;
            end
        end
    end

    // Datapath: shadow write on capture, frame hand-off when mask is full.
    always_comb begin
        dec      = seg_decode(seg_in[7:1]);
        sh_nib_d = sh_nib_q;
        sh_dp_d  = sh_dp_q;
        sh_err_d = sh_err_q;
        seen_d   = (&seen_q) ? '0 : seen_q;
        value_d  = value_q;
        dp_d     = dp_q;
        derr_d   = derr_q;
        err_d    = err_q;
        valid_d  = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (capture && dig_sel[i]) begin
                sh_nib_d[i*4 +: 4] = dec[3:0];
                sh_dp_d[i]         = seg_in[0];
                sh_err_d[i]        = dec[4];
                seen_d[i]          = 1'b1;
            end
        end
        if (&seen_q) begin
            value_d = sh_nib_q;
            dp_d    = sh_dp_q;
            derr_d  = sh_err_q;
            err_d   = |sh_err_q;
            valid_d = 1'b1;
        end
    end

    // Shadow, seen-mask and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seen_q   <= '0;
            sh_nib_q <= '0;
            sh_dp_q  <= '0;
            sh_err_q <= '0;
            value_q  <= '0;
            dp_q     <= '0;
            derr_q   <= '0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            seen_q   <= seen_d;
            sh_nib_q <= sh_nib_d;
            sh_dp_q  <= sh_dp_d;
            sh_err_q <= sh_err_d;
            value_q  <= value_d;
            dp_q     <= dp_d;
            derr_q   <= derr_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
        end
    end

    assign value     = value_q;
    assign dp        = dp_q;
    assign digit_err = derr_q;
    assign err       = err_q;
    assign valid     = valid_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: directed scans plus randomized frames. A reference
// model predicts each completed frame and queues it; a monitor pops and
// compares whenever valid pulses.
module tb_seg7_reader;

    localparam int NDIG   = 8;
    localparam int STABLE = 2;

    logic        clock;
    logic        reset;
    logic [7:0]  seg_in;
    logic [7:0]  dig_sel;
    logic [31:0] value;
    logic [7:0]  dp;
    logic [7:0]  digit_err;
    logic        err;
    logic        valid;

    seg7_reader #(.NDIG(NDIG), .STABLE(STABLE)) dut (
        .clock(clock), .reset(reset), .seg_in(seg_in), .dig_sel(dig_sel),
        .value(value), .dp(dp), .digit_err(digit_err), .err(err), .valid(valid)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [31:0] v;
        logic [7:0]  d;
        logic [7:0]  e;
        logic        er;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Encoder codes of the board's hex-to-segment decoder (a..g, dp).
    logic [7:0] enc [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                             8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h1A, 8'h7A, 8'h9E, 8'h8E};

    // Reference model state: what each digit last showed and which were seen.
    logic [3:0] m_nib [8];
    logic       m_dp  [8];
    logic       m_err [8];
    logic [7:0] m_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_seen = '0;
        for (int i = 0; i < 8; i++) begin
            m_nib[i] = '0; m_dp[i] = 1'b0; m_err[i] = 1'b0;
        end
    endtask

    // A presentation counts if the select is one-hot and held long enough.
    task automatic model_present(input logic [7:0] sel, input logic [7:0] seg, input int dwell);
        int   k;
        exp_t x;
        if (!$onehot(sel) || dwell < STABLE) return;
        k = $clog2(sel);
        m_nib[k] = 4'h0;
        m_err[k] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (enc[i][7:1] == seg[7:1]) begin
                m_nib[k] = 4'(i);
                m_err[k] = 1'b0;
            end
        end
        m_dp[k]   = seg[0];
        m_seen[k] = 1'b1;
        if (m_seen == 8'hFF) begin
            x.er = 1'b0;
            for (int i = 0; i < 8; i++) begin
                x.v[i*4 +: 4] = m_nib[i];
                x.d[i]        = m_dp[i];
                x.e[i]        = m_err[i];
                x.er          = x.er | m_err[i];
            end
            sb.push_back(x);
            m_seen = '0;
        end
    endtask

    // Hold (sel, seg) for dwell cycles, then blank for gap cycles.
    task automatic present(input logic [7:0] sel, input logic [7:0] seg, input int dwell, input int gap);
        model_present(sel, seg, dwell);
        @(negedge clock);
        dig_sel = sel;
        seg_in  = seg;
        repeat (dwell - 1) @(negedge clock);
        if (gap > 0) begin
            @(negedge clock);
            dig_sel = '0;
            seg_in  = '0;
            repeat (gap - 1) @(negedge clock);
        end
    endtask

    function automatic logic [7:0] sel_of(input int k);
        logic [7:0] s;
        s = 8'b1 << k;
        return s;
    endfunction

    task automatic scan(input logic [31:0] val);
        for (int k = 0; k < 8; k++) present(sel_of(k), enc[val[k*4 +: 4]], 4, 1);
    endtask

    function automatic logic [7:0] rand_pat();
        logic [7:0] p;
        if ($urandom_range(0, 4) == 0) p = 8'($urandom);
        else p = enc[$urandom_range(0, 15)] | 8'($urandom_range(0, 1));
        return p;
    endfunction

    // Monitor: every valid pulse must match the oldest predicted frame.
    logic prev_valid = 1'b0;
    always @(posedge clock) begin : mon
        exp_t x;
        #1;
        if (valid) begin
            chk("valid_not_back_to_back", {31'd0, prev_valid}, 32'd0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got value %h, expected no frame at %0t", value, $time);
            end else begin
                x = sb.pop_front();
                chk("value", value, x.v);
                chk("dp", {24'd0, dp}, {24'd0, x.d});
                chk("digit_err", {24'd0, digit_err}, {24'd0, x.e});
                chk("err", {31'd0, err}, {31'd0, x.er});
            end
        end
        prev_valid = valid;
    end

    initial begin
        logic [31:0] w;
        int perm [8];
        int j, t;

        reset   = 1'b1;
        seg_in  = '0;
        dig_sel = '0;
        model_reset();
        repeat (3) @(negedge clock);
        chk("reset_value", value, 32'd0);
        chk("reset_flags", {14'd0, dp, digit_err, err, valid}, 32'd0);
        reset = 1'b0;

        // Plain in-order scan.
        scan(32'h0123_4567);

        // Digit 3 blank pattern -> unrecognised.
        w = 32'h0123_4567;
        for (int k = 0; k < 8; k++) present(sel_of(k), (k == 3) ? 8'h00 : enc[w[k*4 +: 4]], 4, 1);

        // Decimal points on digits 0 and 5.
        for (int k = 0; k < 8; k++)
            present(sel_of(k), (k == 0) ? 8'hFD : (k == 5) ? 8'h9F : 8'hFE, 4, 1);

        // Glitch on digit 2 and a multi-hot select inside a frame.
        w = 32'h89AB_CDEF;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                present(sel_of(2), 8'h60, 1, 0);
                present(sel_of(2), 8'hB6, 3, 1);
                present(8'h03, 8'hFC, 5, 1);
            end else begin
                present(sel_of(k), enc[w[k*4 +: 4]], 4, 1);
            end
        end

        // Out-of-order scan with digit 4 recaptured (2 then 9).
        w = 32'h0123_4567;
        present(sel_of(7), enc[w[31:28]], 3, 1);
        present(sel_of(3), enc[w[15:12]], 3, 1);
        present(sel_of(0), enc[w[3:0]],   3, 1);
        present(sel_of(4), enc[2],        3, 1);
        present(sel_of(1), enc[w[7:4]],   3, 1);
        present(sel_of(2), enc[w[11:8]],  3, 1);
        present(sel_of(4), enc[9],        3, 1);
        present(sel_of(5), enc[w[23:20]], 3, 1);
        present(sel_of(6), enc[w[27:24]], 3, 1);

        // Asynchronous reset part-way through a frame.
        for (int k = 0; k < 5; k++) present(sel_of(k), enc[k], 4, 1);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_value", value, 32'd0);
        chk("async_reset_flags", {14'd0, dp, digit_err, err, valid}, 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        scan(32'hFEDC_BA98);

        // Randomized frames: shuffled order, varied dwell, occasional glitches.
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < 8; i++) perm[i] = i;
            for (int i = 7; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 3) == 0) present(sel_of(perm[i]), rand_pat(), 1, 1);
                if ($urandom_range(0, 7) == 0) present(8'($urandom) | 8'h11, rand_pat(), 4, 1);
                present(sel_of(perm[i]), rand_pat(), $urandom_range(STABLE, 5), $urandom_range(1, 2));
            end
        end

        repeat (10) @(negedge clock);
        chk("frames_outstanding", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        n_bad++;
        $display("FAIL timeout: got no finish, expected finish before limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

endmodule
